csr_trap: RTL and testbench

CSR_TRAP -- requirements
Module: csr_trap

---
 rtl/csr_pkg.sv | 40 ++++
 rtl/csr_trap.sv | 184 ++++++++++++++++++
 tb/tb_csr_trap.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// Shared machine-mode CSR definitions: addresses, field bits, op codes, FSM states.
// Latency: not applicable (declarations only).
// Backpressure: not applicable.
package csr_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS  = 12'h300;
  localparam logic [11:0] CSR_MIE      = 12'h304;
  localparam logic [11:0] CSR_MTVEC    = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;
  localparam logic [11:0] CSR_MEPC     = 12'h341;
  localparam logic [11:0] CSR_MCAUSE   = 12'h342;
  localparam logic [11:0] CSR_MTVAL    = 12'h343;
  localparam logic [11:0] CSR_MIP      = 12'h344;

  // Field bit positions
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
  localparam int MIE_MEIE     = 11;
  localparam int MIP_MEIP     = 11;

  // Cause code reported for the external interrupt
  localparam logic [4:0] IRQ_CAUSE_EXT = 5'd11;

  // funct3 encodings of the CSR instructions
  localparam logic [2:0] F3_RW  = 3'b001;
  localparam logic [2:0] F3_RS  = 3'b010;
  localparam logic [2:0] F3_RC  = 3'b011;
  localparam logic [2:0] F3_RWI = 3'b101;
  localparam logic [2:0] F3_RSI = 3'b110;
  localparam logic [2:0] F3_RCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TAKE     = 2'd1,
    ST_RETURN   = 2'd2,
    ST_REDIRECT = 2'd3
  } state_t;

endpackage

// File: rtl/csr_trap.sv
// Machine-mode CSR file with trap entry/return sequencer and fetch redirect.
// Latency: event accepted in IDLE, redirect_valid two edges later; csr_rd combinational.
// Backpressure: evt_ready low while busy; redirect held stable until redirect_ready.
module csr_trap
  import csr_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        csr_we,
  input  logic [19:0] instr_31_12,
  input  logic [31:0] csr_wd,
  output logic [31:0] csr_rd,
  input  logic        exc_valid,
  input  logic [4:0]  exc_cause,
  input  logic [31:0] exc_pc,
  input  logic [31:0] exc_tval,
  input  logic        irq_ext,
  input  logic [31:0] int_pc,
  input  logic        mret_valid,
  output logic        evt_ready,
  output logic        redirect_valid,
  input  logic        redirect_ready,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  logic [11:0] csr_addr;
  logic [4:0]  zimm;
  logic [2:0]  funct3;

  assign csr_addr = instr_31_12[19:8];
  assign zimm     = instr_31_12[7:3];
  assign funct3   = instr_31_12[2:0];

  state_t state, state_nxt;

  // Architectural CSR state
  logic        st_mie, st_mpie, meie;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;

  // Event captured at acceptance, committed in TAKE
  logic        lat_irq;
  logic [4:0]  lat_cause;
  logic [31:0] lat_pc, lat_tval;

  logic        irq_pend, accept_trap, accept_mret;
  logic        sw_wr;
  logic [31:0] sw_opnd, sw_val;
  logic [31:0] trap_base, trap_target;

  assign irq_pend    = irq_ext & meie & st_mie;
  assign accept_trap = (state == ST_IDLE) && (exc_valid || irq_pend);
  assign accept_mret = (state == ST_IDLE) && !exc_valid && !irq_pend && mret_valid;

  // Vectored mode only offsets interrupts; exceptions always go to the base.
  assign trap_base   = {mtvec[31:2], 2'b00};
  assign trap_target = (lat_irq && (mtvec[1:0] == 2'b01))
                     ? trap_base + {25'd0, lat_cause, 2'b00}
                     : trap_base;

  // Combinational read of the addressed CSR; unmapped addresses read zero
  always_comb begin
    csr_rd = '0;
    case (csr_addr)
      CSR_MSTATUS: begin
        csr_rd[MSTATUS_MIE]  = st_mie;
        csr_rd[MSTATUS_MPIE] = st_mpie;
      end
      CSR_MIE:      csr_rd[MIE_MEIE] = meie;
      CSR_MTVEC:    csr_rd = mtvec;
      CSR_MSCRATCH: csr_rd = mscratch;
      CSR_MEPC:     csr_rd = mepc;
      CSR_MCAUSE:   csr_rd = mcause;
      CSR_MTVAL:    csr_rd = mtval;
      CSR_MIP:      csr_rd[MIP_MEIP] = irq_ext;
      default:      csr_rd = '0;
    endcase
  end

  // Software read-modify-write value; only honoured while idle
  always_comb begin
    sw_opnd = funct3[2] ? {27'd0, zimm} : csr_wd;
    sw_wr   = 1'b0;
    sw_val  = csr_rd;
    if (csr_we && (state == ST_IDLE)) begin
      case (funct3)
        F3_RW, F3_RWI: begin sw_wr = 1'b1; sw_val = sw_opnd;           end
        F3_RS, F3_RSI: begin sw_wr = 1'b1; sw_val = csr_rd | sw_opnd;  end
        F3_RC, F3_RCI: begin sw_wr = 1'b1; sw_val = csr_rd & ~sw_opnd; end
        default:       begin sw_wr = 1'b0; sw_val = csr_rd;            end
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // FSM next-state: exception > pending interrupt > mret
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept_trap)      state_nxt = ST_TAKE;
        else if (accept_mret) state_nxt = ST_RETURN;
      end
      ST_TAKE:     state_nxt = ST_REDIRECT;
      ST_RETURN:   state_nxt = ST_REDIRECT;
      ST_REDIRECT: if (redirect_ready) state_nxt = ST_IDLE;
      default:     state_nxt = ST_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    evt_ready      = (state == ST_IDLE);
    busy           = (state != ST_IDLE);
    redirect_valid = (state == ST_REDIRECT);
  end

  // CSR datapath: software writes first, trap/return commits override them
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_mie      <= 1'b0;
      st_mpie     <= 1'b0;
      meie        <= 1'b0;
      mtvec       <= RESET_MTVEC;
      mscratch    <= '0;
      mepc        <= '0;
      mcause      <= '0;
      mtval       <= '0;
      lat_irq     <= 1'b0;
      lat_cause   <= '0;
      lat_pc      <= '0;
      lat_tval    <= '0;
      redirect_pc <= '0;
    end else begin
      if (sw_wr) begin
        case (csr_addr)
          CSR_MSTATUS: begin
            st_mie  <= sw_val[MSTATUS_MIE];
            st_mpie <= sw_val[MSTATUS_MPIE];
          end
          CSR_MIE:      meie     <= sw_val[MIE_MEIE];
          CSR_MTVEC:    mtvec    <= sw_val;
          CSR_MSCRATCH: mscratch <= sw_val;
          CSR_MEPC:     mepc     <= sw_val & 32'hFFFF_FFFC;
          CSR_MCAUSE:   mcause   <= sw_val;
          CSR_MTVAL:    mtval    <= sw_val;
          default:      ;
        endcase
      end
      case (state)
        ST_IDLE: begin
          if (accept_trap) begin
            lat_irq   <= !exc_valid;
            lat_cause <= exc_valid ? exc_cause : IRQ_CAUSE_EXT;
            lat_pc    <= exc_valid ? exc_pc : int_pc;
            lat_tval  <= exc_valid ? exc_tval : 32'd0;
          end
        end
        ST_TAKE: begin
          mepc        <= lat_pc & 32'hFFFF_FFFC;
          mcause      <= {lat_irq, 26'd0, lat_cause};
          mtval       <= lat_tval;
          st_mpie     <= st_mie;
          st_mie      <= 1'b0;
          redirect_pc <= trap_target;
        end
        ST_RETURN: begin
          st_mie      <= st_mpie;
          st_mpie     <= 1'b1;
          redirect_pc <= mepc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_csr_trap.sv
// Self-checking bench for csr_trap: directed scenarios plus random traffic vs a transaction-level model.
// Latency: not applicable.
// Backpressure: redirect_ready held low for chosen stall counts.
module tb_csr_trap;
  import csr_pkg::*;

  localparam logic [31:0] TB_MTVEC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        csr_we = 1'b0;
  logic [19:0] instr_31_12 = '0;
  logic [31:0] csr_wd = '0;
  logic [31:0] csr_rd;
  logic        exc_valid = 1'b0;
  logic [4:0]  exc_cause = '0;
  logic [31:0] exc_pc = '0;
  logic [31:0] exc_tval = '0;
  logic        irq_ext = 1'b0;
  logic [31:0] int_pc = '0;
  logic        mret_valid = 1'b0;
  logic        evt_ready;
  logic        redirect_valid;
  logic        redirect_ready = 1'b0;
  logic [31:0] redirect_pc;
  logic        busy;

  always #10 clk = ~clk;

  csr_trap #(.RESET_MTVEC(TB_MTVEC)) dut (
    .clk(clk), .reset_n(reset_n), .csr_we(csr_we), .instr_31_12(instr_31_12),
    .csr_wd(csr_wd), .csr_rd(csr_rd), .exc_valid(exc_valid), .exc_cause(exc_cause),
    .exc_pc(exc_pc), .exc_tval(exc_tval), .irq_ext(irq_ext), .int_pc(int_pc),
    .mret_valid(mret_valid), .evt_ready(evt_ready), .redirect_valid(redirect_valid),
    .redirect_ready(redirect_ready), .redirect_pc(redirect_pc), .busy(busy)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  // ---------------- reference model (architectural view) ----------------
  logic        m_mie, m_mpie, m_meie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
  logic [31:0] last_rpc;

  function automatic void m_reset();
    m_mie = 0; m_mpie = 0; m_meie = 0;
    m_mtvec = TB_MTVEC; m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
  endfunction

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      CSR_MSTATUS:  return {24'd0, m_mpie, 3'd0, m_mie, 3'd0};
      CSR_MIE:      return {20'd0, m_meie, 11'd0};
      CSR_MTVEC:    return m_mtvec;
      CSR_MSCRATCH: return m_mscratch;
      CSR_MEPC:     return m_mepc;
      CSR_MCAUSE:   return m_mcause;
      CSR_MTVAL:    return m_mtval;
      CSR_MIP:      return {20'd0, irq_ext, 11'd0};
      default:      return 32'd0;
    endcase
  endfunction

  function automatic void m_sw(input logic [2:0] f3, input logic [11:0] a,
                               input logic [31:0] wd, input logic [4:0] z);
    logic [31:0] opnd, nv;
    opnd = f3[2] ? {27'd0, z} : wd;
    case (f3[1:0])
      2'b01:   nv = opnd;
      2'b10:   nv = m_read(a) | opnd;
      2'b11:   nv = m_read(a) & ~opnd;
      default: return;
    endcase
    case (a)
      CSR_MSTATUS:  begin m_mie = nv[3]; m_mpie = nv[7]; end
      CSR_MIE:      m_meie = nv[11];
      CSR_MTVEC:    m_mtvec = nv;
      CSR_MSCRATCH: m_mscratch = nv;
      CSR_MEPC:     m_mepc = nv & 32'hFFFF_FFFC;
      CSR_MCAUSE:   m_mcause = nv;
      CSR_MTVAL:    m_mtval = nv;
      default:      ;
    endcase
  endfunction

  function automatic logic [11:0] pick_addr(input int i);
    case (i)
      0: return CSR_MSTATUS;  1: return CSR_MIE;    2: return CSR_MTVEC;
      3: return CSR_MSCRATCH; 4: return CSR_MEPC;   5: return CSR_MCAUSE;
      6: return CSR_MTVAL;    7: return CSR_MIP;    default: return 12'h7C0;
    endcase
  endfunction

  // ---------------- stimulus tasks ----------------
  task automatic check_all(input string tag);
    logic [11:0] a;
    @(negedge clk);
    csr_we = 0;
    for (int i = 0; i < 9; i++) begin
      a = pick_addr(i);
      instr_31_12 = {a, 8'd0};
      #1;
      check_eq($sformatf("%s_%03h", tag, a), csr_rd, m_read(a));
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] v);
    instr_31_12 = {a, 8'd0};
    #1;
    v = csr_rd;
  endtask

  task automatic sw_op(input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] wd, input logic [4:0] z);
    @(negedge clk);
    csr_we = 1; instr_31_12 = {a, z, f3}; csr_wd = wd;
    m_sw(f3, a, wd, z);
    @(negedge clk);
    csr_we = 0;
    #1;
    check_eq($sformatf("sw_%03h", a), csr_rd, m_read(a));
  endtask

  // Starts at the negedge right after the accepting edge.
  task automatic finish_event(input int kind, input logic [4:0] cause, input logic [31:0] pc,
                              input logic [31:0] tval, input int stall);
    logic [31:0] tgt;
    int edges;
    exc_valid = 0; mret_valid = 0; csr_we = 0;
    #1;
    check_eq("busy_after_accept", {31'd0, busy}, 32'd1);
    check_eq("rv_early", {31'd0, redirect_valid}, 32'd0);
    if (kind == 0) begin
      tgt = {m_mtvec[31:2], 2'b00};
      m_mepc = pc & 32'hFFFF_FFFC; m_mcause = {27'd0, cause}; m_mtval = tval;
      m_mpie = m_mie; m_mie = 0;
    end else if (kind == 1) begin
      tgt = {m_mtvec[31:2], 2'b00};
      if (m_mtvec[1:0] == 2'b01) tgt = tgt + 32'd44;
      m_mepc = pc & 32'hFFFF_FFFC; m_mcause = 32'h8000_000B; m_mtval = 0;
      m_mpie = m_mie; m_mie = 0;
    end else begin
      tgt = m_mepc;
      m_mie = m_mpie; m_mpie = 1;
    end
    edges = 1;
    while (!redirect_valid && edges < 16) begin
      @(negedge clk); #1; edges++;
    end
    check_eq("rv_rise", {31'd0, (redirect_valid && edges >= 2)}, 32'd1);
    check_eq("rpc", redirect_pc, tgt);
    last_rpc = redirect_pc;
    for (int i = 0; i < stall; i++) begin
      csr_we = 1; instr_31_12 = {CSR_MSCRATCH, 5'd0, F3_RW}; csr_wd = $urandom;
      @(negedge clk); #1;
      check_eq("rv_hold", {31'd0, redirect_valid}, 32'd1);
      check_eq("rpc_hold", redirect_pc, tgt);
    end
    csr_we = 0; redirect_ready = 1;
    @(negedge clk);
    redirect_ready = 0;
    #1;
    check_eq("idle_back", {31'd0, evt_ready}, 32'd1);
    check_eq("rv_drop", {31'd0, redirect_valid}, 32'd0);
  endtask

  // kind: 0 exception, 1 interrupt, 2 mret; optional software write in the accepting cycle
  task automatic run_event(input int kind, input logic [4:0] cause, input logic [31:0] pc,
                           input logic [31:0] tval, input logic irq_also, input int stall,
                           input logic do_sw, input logic [11:0] sw_a, input logic [31:0] sw_v);
    @(negedge clk);
    exc_valid = (kind == 0); irq_ext = (kind == 1) || irq_also; mret_valid = (kind == 2);
    exc_cause = cause; exc_pc = pc; exc_tval = tval; int_pc = pc;
    if (do_sw) begin
      csr_we = 1; instr_31_12 = {sw_a, 5'd0, F3_RW}; csr_wd = sw_v;
      m_sw(F3_RW, sw_a, sw_v, 5'd0);
    end
    #1;
    check_eq("evt_ready_idle", {31'd0, evt_ready}, 32'd1);
    @(negedge clk);
    if (!irq_also) irq_ext = 0;
    finish_event(kind, cause, pc, tval, stall);
  endtask

  // ---------------- main sequence ----------------
  logic [31:0] v;

  initial begin
    m_reset();
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_evt_ready", {31'd0, evt_ready}, 32'd1);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("rst_rpc", redirect_pc, 32'd0);
    check_all("rst");
    @(negedge clk); reset_n = 1;
    check_all("post_rst");

    // Direct exception; a same-cycle mepc write is overwritten by the trap
    sw_op(F3_RW, CSR_MTVEC, 32'h100, 5'd0);
    sw_op(F3_RSI, CSR_MSTATUS, 32'd0, 5'd8);
    run_event(0, 5'd2, 32'h40, 32'hDEAD, 1'b0, 0, 1'b1, CSR_MEPC, 32'h9990);
    @(negedge clk);
    rd(CSR_MEPC, v);    check_eq("exc_mepc", v, 32'h40);
    rd(CSR_MCAUSE, v);  check_eq("exc_mcause", v, 32'h2);
    rd(CSR_MTVAL, v);   check_eq("exc_mtval", v, 32'hDEAD);
    rd(CSR_MSTATUS, v); check_eq("exc_mstatus", v, 32'h80);
    check_eq("exc_rpc", last_rpc, 32'h100);
    check_all("exc");

    // Vectored interrupt
    sw_op(F3_RW, CSR_MTVEC, 32'h201, 5'd0);
    sw_op(F3_RW, CSR_MIE, 32'h800, 5'd0);
    sw_op(F3_RSI, CSR_MSTATUS, 32'd0, 5'd8);
    run_event(1, 5'd0, 32'h88, 32'd0, 1'b0, 0, 1'b0, 12'h0, 32'd0);
    @(negedge clk);
    rd(CSR_MCAUSE, v); check_eq("irq_mcause", v, 32'h8000_000B);
    rd(CSR_MEPC, v);   check_eq("irq_mepc", v, 32'h88);
    check_eq("irq_rpc", last_rpc, 32'h22C);

    // MRET
    sw_op(F3_RW, CSR_MEPC, 32'h44, 5'd0);
    run_event(2, 5'd0, 32'd0, 32'd0, 1'b0, 0, 1'b0, 12'h0, 32'd0);
    @(negedge clk);
    rd(CSR_MSTATUS, v); check_eq("mret_mstatus", v, 32'h88);
    check_eq("mret_rpc", last_rpc, 32'h44);

    // Priority and stall: exception wins, interrupt taken once re-enabled
    run_event(0, 5'd5, 32'h60, 32'h1234, 1'b1, 3, 1'b0, 12'h0, 32'd0);
    @(negedge clk);
    rd(CSR_MCAUSE, v); check_eq("prio_exc_first", v, 32'h5);
    check_all("prio");
    int_pc = 32'h90;
    sw_op(F3_RSI, CSR_MSTATUS, 32'd0, 5'd8);
    @(negedge clk);
    irq_ext = 0;
    finish_event(1, 5'd11, 32'h90, 32'd0, 0);
    @(negedge clk);
    rd(CSR_MCAUSE, v); check_eq("prio_irq_after", v, 32'h8000_000B);
    check_all("prio2");

    // Software ops and masking
    sw_op(F3_RSI, CSR_MSTATUS, 32'd0, 5'd8);
    sw_op(F3_RC, CSR_MIE, 32'h800, 5'd0);
    sw_op(F3_RW, CSR_MEPC, 32'h7, 5'd0);
    sw_op(F3_RW, 12'h7C0, 32'h1234, 5'd0);
    @(negedge clk);
    rd(CSR_MSTATUS, v); check_eq("sw_mie", v & 32'h8, 32'h8);
    rd(CSR_MIE, v);     check_eq("sw_meie", v, 32'h0);
    rd(CSR_MEPC, v);    check_eq("sw_mepc", v, 32'h4);
    rd(12'h7C0, v);     check_eq("sw_unmapped", v, 32'h0);

    // Reset while in TAKE
    sw_op(F3_RW, CSR_MSCRATCH, 32'hCAFE, 5'd0);
    @(negedge clk);
    exc_valid = 1; exc_cause = 5'd3; exc_pc = 32'h70; exc_tval = 32'h55;
    @(negedge clk);
    exc_valid = 0;
    #1;
    check_eq("take_busy", {31'd0, busy}, 32'd1);
    reset_n = 0;
    #1;
    check_eq("rst_take_rv", {31'd0, redirect_valid}, 32'd0);
    check_eq("rst_take_ready", {31'd0, evt_ready}, 32'd1);
    check_eq("rst_take_rpc", redirect_pc, 32'd0);
    m_reset();
    check_all("rst_take");
    @(negedge clk); reset_n = 1;
    repeat (3) @(negedge clk);
    #1;
    check_eq("rst_take_idle", {31'd0, redirect_valid}, 32'd0);
    check_all("rst_take_after");

    // Random traffic
    for (int it = 0; it < 60; it++) begin
      int act;
      act = $urandom_range(0, 4);
      if (act <= 1) begin
        sw_op(3'($urandom_range(0, 7)), pick_addr($urandom_range(0, 8)), $urandom,
              5'($urandom_range(0, 31)));
      end else if (act == 2) begin
        run_event(0, 5'($urandom_range(0, 31)), $urandom, $urandom, 1'b0,
                  $urandom_range(0, 3), ($urandom_range(0, 2) == 0),
                  pick_addr($urandom_range(0, 8)), $urandom);
        check_all("rnd_exc");
      end else if (act == 3) begin
        if (m_mie && m_meie) begin
          run_event(1, 5'd0, $urandom, 32'd0, 1'b0, $urandom_range(0, 3),
                    ($urandom_range(0, 2) == 0), pick_addr($urandom_range(0, 8)), $urandom);
          check_all("rnd_irq");
        end else begin
          @(negedge clk);
          irq_ext = 1;
          rd(CSR_MIP, v); check_eq("rnd_mip", v, 32'h800);
          @(negedge clk);
          irq_ext = 0;
          #1;
          check_eq("rnd_masked", {31'd0, evt_ready}, 32'd1);
        end
      end else begin
        run_event(2, 5'd0, 32'd0, 32'd0, 1'b0, $urandom_range(0, 3),
                  ($urandom_range(0, 2) == 0), pick_addr($urandom_range(0, 8)), $urandom);
        check_all("rnd_mret");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
